// File: rtl/chaos_chk_pkg.sv
// Shared types and helpers for the chaos checkpoint monitor: FSM states,
// default parameters and the masked compare used by every stage.
package chaos_chk_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, PASS, FAIL} chk_state_e;

  localparam int CHK_WIDTH      = 16;
  localparam int CHK_DEPTH      = 8;
  localparam int CHK_TMO_W      = 24;
  localparam int CHK_STABLE_CYC = 4;
  // widest observation bus the compare helper handles
  localparam int CHK_MAX_W      = 64;

  function automatic logic chk_match(input logic [CHK_MAX_W-1:0] obs,
                                     input logic [CHK_MAX_W-1:0] exp_v,
                                     input logic [CHK_MAX_W-1:0] mask);
    return ((obs ^ exp_v) & mask) == '0;
  endfunction

endpackage

// File: rtl/chaos_checkpoint_monitor_if.sv
// Table-load, control, observation and status bundle of the checkpoint monitor.
interface chaos_chk_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int TMO_W = 24
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int NS_W  = $clog2(DEPTH + 1);

  logic             load_en;
  logic [IDX_W-1:0] load_idx;
  logic [WIDTH-1:0] load_data;
  logic [WIDTH-1:0] load_mask;
  logic [NS_W-1:0]  num_stages;
  logic [TMO_W-1:0] tmo_limit;
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] obs;
  logic             busy;
  logic             pass;
  logic             fail;
  logic [NS_W-1:0]  stage;
  logic [NS_W-1:0]  fail_stage;
  logic             stage_hit;

  modport master (
    output load_en, load_idx, load_data, load_mask, num_stages, tmo_limit,
           start, abort, obs,
    input  busy, pass, fail, stage, fail_stage, stage_hit
  );

  modport slave (
    input  load_en, load_idx, load_data, load_mask, num_stages, tmo_limit,
           start, abort, obs,
    output busy, pass, fail, stage, fail_stage, stage_hit
  );
endinterface

// File: rtl/chaos_chk_stable.sv
// Match qualification filter. With CHAOS_CHK_STABLE_EN a match must hold for
// STABLE_CYC consecutive cycles; otherwise match_in passes straight through.
module chaos_chk_stable #(
  parameter int STABLE_CYC = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic match_in,
  output logic match_q
);
`ifdef CHAOS_CHK_STABLE_EN
  localparam int SC_W = $clog2(STABLE_CYC + 1);

  logic [SC_W-1:0] run;

  // run counts prior consecutive matching cycles, saturating at the threshold
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 run <= '0;
    else if (clr || !match_in) run <= '0;
    else if (!match_q)         run <= run + 1'b1;
  end

  assign match_q = match_in && (run >= SC_W'(STABLE_CYC - 1));
`else
  logic unused_ok;
  assign unused_ok = ^{clock, reset, clr, (STABLE_CYC > 0)};
  assign match_q   = match_in;
`endif
endmodule

// File: rtl/chaos_checkpoint_monitor.sv
// Ordered checkpoint sequencer: walks a table of masked expected values against
// the observation bus with a per-stage timeout. Optional CHAOS_CHK_STABLE_EN.
module chaos_checkpoint_monitor
  import chaos_chk_pkg::*;
#(
  parameter int WIDTH      = CHK_WIDTH,
  parameter int DEPTH      = CHK_DEPTH,
  parameter int TMO_W      = CHK_TMO_W,
  parameter int STABLE_CYC = CHK_STABLE_CYC
) (
  input  logic        clock,
  input  logic        reset,
  chaos_chk_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int NS_W  = $clog2(DEPTH + 1);

  chk_state_e       state, state_n;
  logic [WIDTH-1:0] exp_tab  [DEPTH];
  logic [WIDTH-1:0] mask_tab [DEPTH];
  logic [WIDTH-1:0] obs_q;
  logic [NS_W-1:0]  stage, stage_n, ns_q, ns_n, fstage, fstage_n;
  logic [TMO_W-1:0] tmo_q, tmo_n, cnt, cnt_n;
  logic             hit, hit_n, match_raw, match_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        exp_tab[i]  <= '0;
        mask_tab[i] <= '1;
      end
    end else if (bus.load_en && state != ARMED) begin
      exp_tab[bus.load_idx]  <= bus.load_data;
      mask_tab[bus.load_idx] <= bus.load_mask;
    end
  end

  // stage is only used as an index while ARMED, where it is below num_stages
  assign match_raw = (state == ARMED) &&
                     chk_match(CHK_MAX_W'(obs_q),
                               CHK_MAX_W'(exp_tab[stage[IDX_W-1:0]]),
                               CHK_MAX_W'(mask_tab[stage[IDX_W-1:0]]));

  chaos_chk_stable #(.STABLE_CYC(STABLE_CYC)) u_stable (
    .clock    (clock),
    .reset    (reset),
    .clr      ((state != ARMED) || match_q),
    .match_in (match_raw),
    .match_q  (match_q)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      obs_q  <= '0;
      stage  <= '0;
      ns_q   <= '0;
      tmo_q  <= '0;
      cnt    <= '0;
      fstage <= '0;
      hit    <= 1'b0;
    end else begin
      state  <= state_n;
      obs_q  <= bus.obs;
      stage  <= stage_n;
      ns_q   <= ns_n;
      tmo_q  <= tmo_n;
      cnt    <= cnt_n;
      fstage <= fstage_n;
      hit    <= hit_n;
    end
  end

  always_comb begin
    state_n  = state;
    stage_n  = stage;
    ns_n     = ns_q;
    tmo_n    = tmo_q;
    cnt_n    = cnt;
    fstage_n = fstage;
    hit_n    = 1'b0;
    if (bus.abort) begin
      state_n  = IDLE;
      stage_n  = '0;
      cnt_n    = '0;
      fstage_n = '0;
    end else begin
      case (state)
        ARMED: begin
          // a match on the timeout cycle still advances
          if (match_q) begin
            hit_n   = 1'b1;
            cnt_n   = '0;
            stage_n = stage + 1'b1;
            if (stage == ns_q - 1'b1) state_n = PASS;
          end else if (tmo_q != '0 && cnt == tmo_q) begin
            state_n  = FAIL;
            fstage_n = stage;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          if (bus.start) begin
            ns_n     = bus.num_stages;
            tmo_n    = bus.tmo_limit;
            stage_n  = '0;
            cnt_n    = '0;
            fstage_n = '0;
            if (bus.num_stages == '0 || bus.num_stages > NS_W'(DEPTH)) state_n = FAIL;
            else                                                       state_n = ARMED;
          end
        end
      endcase
    end
  end

  assign bus.busy       = (state == ARMED);
  assign bus.pass       = (state == PASS);
  assign bus.fail       = (state == FAIL);
  assign bus.stage      = stage;
  assign bus.fail_stage = fstage;
  assign bus.stage_hit  = hit;

endmodule

// File: tb/tb_chaos_checkpoint_monitor.sv
// Directed bench for chaos_checkpoint_monitor; honours CHAOS_CHK_STABLE_EN.
module tb_chaos_checkpoint_monitor;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int TMO_W = 24;
`ifdef CHAOS_CHK_STABLE_EN
  localparam int SOFF = 3;
`else
  localparam int SOFF = 0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   hits  = 0;
  logic [15:0] seq [5] = '{16'hAB40, 16'hAB41, 16'h0000, 16'hFFFF, 16'hAB51};

  chaos_chk_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TMO_W(TMO_W)) bus ();

  chaos_checkpoint_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TMO_W(TMO_W), .STABLE_CYC(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(negedge clock) if (bus.stage_hit) hits++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_chk++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic load(input logic [2:0] idx, input logic [15:0] d, input logic [15:0] m);
    bus.load_en = 1'b1; bus.load_idx = idx; bus.load_data = d; bus.load_mask = m;
    tick(1);
    bus.load_en = 1'b0;
  endtask

  task automatic go(input logic [3:0] ns, input logic [23:0] tmo);
    bus.num_stages = ns; bus.tmo_limit = tmo; bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic do_abort();
    bus.abort = 1'b1; tick(1); bus.abort = 1'b0;
  endtask

  task automatic to_stage3();
    bus.obs = 16'h1234;
    go(5, 1000);
    for (int i = 0; i < 3; i++) begin bus.obs = seq[i]; tick(8); end
  endtask

  initial begin
    int n, h0;
    bus.load_en = 0; bus.load_idx = '0; bus.load_data = '0; bus.load_mask = '0;
    bus.num_stages = '0; bus.tmo_limit = '0; bus.start = 0; bus.abort = 0; bus.obs = '0;
    tick(3);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_pass", 32'(bus.pass), 0);
    chk("rst_fail", 32'(bus.fail), 0);
    chk("rst_stage", 32'(bus.stage), 0);
    chk("rst_hit", 32'(bus.stage_hit), 0);
    reset = 1'b0;
    tick(1);

    // reset table is value 0 / mask all-ones, so obs=0 passes one stage
    go(1, 0); tick(8);
    chk("rsttab_pass", 32'(bus.pass), 1);
    chk("rsttab_stage", 32'(bus.stage), 1);

    // illegal configurations
    go(0, 10); tick(1);
    chk("ns0_fail", 32'(bus.fail), 1);
    chk("ns0_fstage", 32'(bus.fail_stage), 0);
    go(9, 10); tick(1);
    chk("ns9_fail", 32'(bus.fail), 1);

    // full five-stage pass
    for (int i = 0; i < 5; i++) load(3'(i), seq[i], 16'hFFFF);
    bus.obs = 16'h1234;
    h0 = hits;
    go(5, 1000);
    chk("seq_busy", 32'(bus.busy), 1);
    for (int i = 0; i < 5; i++) begin bus.obs = seq[i]; tick(50); end
    chk("seq_hits", 32'(hits - h0), 5);
    chk("seq_pass", 32'(bus.pass), 1);
    chk("seq_fail", 32'(bus.fail), 0);
    chk("seq_stage", 32'(bus.stage), 5);
    chk("seq_busy_end", 32'(bus.busy), 0);

    // stuck at AB41: timeout in stage 2 exactly 1001 edges after entry
    bus.obs = 16'h1234;
    go(5, 1000);
    bus.obs = 16'hAB40; tick(10);
    bus.obs = 16'hAB41;
    n = 0;
    while (bus.stage != 2 && n < 100) begin tick(1); n++; end
    chk("tmo_reach2", 32'(bus.stage), 2);
    n = 0;
    while (!bus.fail && n < 1100) begin tick(1); n++; end
    chk("tmo_latency", n, 1001);
    chk("tmo_fstage", 32'(bus.fail_stage), 2);
    chk("tmo_pass", 32'(bus.pass), 0);
    chk("tmo_busy", 32'(bus.busy), 0);

    // masked compare
    load(0, 16'hAB40, 16'hFF00);
    bus.obs = 16'hAB7F;
    go(1, 0); tick(8);
    chk("mask_ff00_pass", 32'(bus.pass), 1);
    load(0, 16'hAB40, 16'hFFFF);
    go(1, 20); tick(8);
    chk("mask_ffff_stage", 32'(bus.stage), 0);
    chk("mask_ffff_busy", 32'(bus.busy), 1);
    tick(25);
    chk("mask_ffff_fail", 32'(bus.fail), 1);
    chk("mask_ffff_fstage", 32'(bus.fail_stage), 0);

    // match on the timeout cycle wins
    bus.obs = 16'h0000;
    go(2, 10); tick(9 - SOFF);
    bus.obs = 16'hAB40; tick(2 + SOFF);
    chk("edge_stage", 32'(bus.stage), 1);
    chk("edge_hit", 32'(bus.stage_hit), 1);
    chk("edge_nofail", 32'(bus.fail), 0);
    do_abort();
    // one cycle later the timeout is taken
    bus.obs = 16'h0000;
    go(2, 10); tick(10 - SOFF);
    bus.obs = 16'hAB40; tick(1 + SOFF);
    chk("late_fail", 32'(bus.fail), 1);
    chk("late_fstage", 32'(bus.fail_stage), 0);
    do_abort();

    // writes and start are ignored while ARMED
    bus.obs = 16'h1234;
    go(5, 1000);
    load(0, 16'h1234, 16'hFFFF);
    tick(8);
    chk("armed_write", 32'(bus.stage), 0);
    go(0, 5);
    chk("armed_start_busy", 32'(bus.busy), 1);
    chk("armed_start_fail", 32'(bus.fail), 0);
    do_abort();

    // abort at stage 3, then rerun from stage 0
    to_stage3();
    chk("abort_pre_stage", 32'(bus.stage), 3);
    do_abort();
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_stage", 32'(bus.stage), 0);
    chk("abort_pf", 32'({bus.pass, bus.fail}), 0);
    bus.obs = 16'h1234;
    go(5, 1000);
    chk("rerun_stage0", 32'(bus.stage), 0);
    for (int i = 0; i < 5; i++) begin bus.obs = seq[i]; tick(8); end
    chk("rerun_pass", 32'(bus.pass), 1);
    chk("rerun_stage", 32'(bus.stage), 5);

    // asynchronous reset at stage 3, seen before the next clock edge
    to_stage3();
    chk("rst_pre_stage", 32'(bus.stage), 3);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_stage", 32'(bus.stage), 0);
    reset = 1'b0;
    tick(1);
    for (int i = 0; i < 5; i++) load(3'(i), seq[i], 16'hFFFF);
    bus.obs = 16'h1234;
    go(5, 1000);
    for (int i = 0; i < 5; i++) begin bus.obs = seq[i]; tick(8); end
    chk("arst_rerun_pass", 32'(bus.pass), 1);

    // match qualification
    do_abort();
    bus.obs = 16'h0000;
    go(2, 0);
`ifdef CHAOS_CHK_STABLE_EN
    bus.obs = 16'hAB40; tick(3);
    bus.obs = 16'h0000; tick(6);
    chk("glitch3_stage", 32'(bus.stage), 0);
    bus.obs = 16'hAB40; tick(4);
    bus.obs = 16'h0000; tick(4);
    chk("hold4_stage", 32'(bus.stage), 1);
`else
    bus.obs = 16'hAB40; tick(1);
    bus.obs = 16'h0000; tick(4);
    chk("glitch1_stage", 32'(bus.stage), 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
